// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: synchronised rx, 3-sample majority vote per bit,
// false-start rejection and registered parity/framing/overrun/break reporting.
module uart_rx_param #(
  parameter int DATA_BITS   = 8,
  parameter int OVERSAMPLE  = 16,
  parameter int PARITY      = 0,
  parameter int STOP_BITS   = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 sys_clk,
  input  logic                 rst_n,
  input  logic                 rx_clk_en,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_ready,
  input  logic                 rx_ready_clear,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun_err,
  output logic                 break_det,
  output logic                 busy
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = 4;

  localparam logic [TW-1:0] T_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] T_S0   = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] T_S1   = TW'(OVERSAMPLE / 2);
  localparam logic [TW-1:0] T_DEC  = TW'(OVERSAMPLE / 2 + 1);

  localparam logic [BW-1:0] B_DATA_LAST = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] B_STOP_LAST = BW'(STOP_BITS - 1);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_START     = 3'd1;
  localparam logic [2:0] S_DATA      = 3'd2;
  localparam logic [2:0] S_PARITY    = 3'd3;
  localparam logic [2:0] S_STOP      = 3'd4;
  localparam logic [2:0] S_WAIT_IDLE = 3'd5;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_s;
  logic [2:0]             state;
  logic [TW-1:0]          tick_cnt;
  logic [BW-1:0]          bit_cnt;
  logic [DATA_BITS-1:0]   shift_q;
  logic                   par_q;
  logic                   stop_ok_q;
  logic                   stop_low_q;
  logic                   samp0;
  logic                   samp1;
  logic                   vote;

  logic                   done_q;
  logic [DATA_BITS-1:0]   done_data;
  logic                   done_perr;
  logic                   done_ferr;
  logic                   done_brk;

  logic                   final_stop_ok;
  logic                   final_stop_low;
  logic                   ones_odd;
  logic                   perr_calc;
  logic                   brk_calc;

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
    end
  end

  assign rx_s = sync_q[SYNC_STAGES-1];
  assign vote = (samp0 & samp1) | (samp0 & rx_s) | (samp1 & rx_s);

  // Frame status as it stands at the decision point of the final stop bit.
  assign final_stop_ok  = stop_ok_q & vote;
  assign final_stop_low = stop_low_q & ~vote;
  assign ones_odd       = (^shift_q) ^ par_q;
  assign perr_calc      = (PARITY == 1) ? ~ones_odd :
                          (PARITY == 2) ?  ones_odd : 1'b0;
  assign brk_calc       = (shift_q == '0) && ((PARITY == 0) || !par_q) && final_stop_low;

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      tick_cnt   <= '0;
      bit_cnt    <= '0;
      shift_q    <= '0;
      par_q      <= 1'b0;
      stop_ok_q  <= 1'b1;
      stop_low_q <= 1'b1;
      samp0      <= 1'b1;
      samp1      <= 1'b1;
      done_q     <= 1'b0;
      done_data  <= '0;
      done_perr  <= 1'b0;
      done_ferr  <= 1'b0;
      done_brk   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (rx_clk_en) begin
        if (tick_cnt == T_S0) samp0 <= rx_s;
        if (tick_cnt == T_S1) samp1 <= rx_s;
        if (state != S_IDLE && state != S_WAIT_IDLE) begin
          tick_cnt <= (tick_cnt == T_LAST) ? '0 : tick_cnt + TW'(1);
        end
        case (state)
          S_IDLE: begin
            if (!rx_s) begin
              state    <= S_START;
              tick_cnt <= TW'(1);
              par_q    <= 1'b0;
            end
          end
          S_START: begin
            if (tick_cnt == T_DEC && vote) begin
              state    <= S_IDLE;
              tick_cnt <= '0;
            end else if (tick_cnt == T_LAST) begin
              state   <= S_DATA;
              bit_cnt <= '0;
            end
          end
          S_DATA: begin
            if (tick_cnt == T_DEC) shift_q <= {vote, shift_q[DATA_BITS-1:1]};
            if (tick_cnt == T_LAST) begin
              if (bit_cnt == B_DATA_LAST) begin
                bit_cnt    <= '0;
                stop_ok_q  <= 1'b1;
                stop_low_q <= 1'b1;
                state      <= (PARITY != 0) ? S_PARITY : S_STOP;
              end else begin
                bit_cnt <= bit_cnt + BW'(1);
              end
            end
          end
          S_PARITY: begin
            if (tick_cnt == T_DEC) par_q <= vote;
            if (tick_cnt == T_LAST) state <= S_STOP;
          end
          S_STOP: begin
            // The frame completes mid final stop bit so a back-to-back start edge is not missed.
            if (tick_cnt == T_DEC) begin
              stop_ok_q  <= final_stop_ok;
              stop_low_q <= final_stop_low;
              if (bit_cnt == B_STOP_LAST) begin
                done_q    <= 1'b1;
                done_data <= shift_q;
                done_perr <= perr_calc;
                done_ferr <= ~final_stop_ok;
                done_brk  <= brk_calc;
                tick_cnt  <= '0;
                bit_cnt   <= '0;
                state     <= final_stop_ok ? S_IDLE : S_WAIT_IDLE;
              end
            end else if (tick_cnt == T_LAST) begin
              bit_cnt <= bit_cnt + BW'(1);
            end
          end
          S_WAIT_IDLE: begin
            if (rx_s) state <= S_IDLE;
          end
          default: begin
            state    <= S_IDLE;
            tick_cnt <= '0;
          end
        endcase
      end
    end
  end

  // A completion in the same cycle as a clear is taken as a fresh frame.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_data     <= '0;
      rx_ready    <= 1'b0;
      parity_err  <= 1'b0;
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
      break_det   <= 1'b0;
    end else if (done_q) begin
      if (!rx_ready || rx_ready_clear) begin
        rx_data     <= done_data;
        rx_ready    <= 1'b1;
        parity_err  <= done_perr;
        frame_err   <= done_ferr;
        break_det   <= done_brk;
        overrun_err <= 1'b0;
      end else begin
        overrun_err <= 1'b1;
      end
    end else if (rx_ready_clear) begin
      rx_ready    <= 1'b0;
      parity_err  <= 1'b0;
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
      break_det   <= 1'b0;
    end
  end

  assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: three frame formats (8N1, 8E1, 7O2) driven serially,
// expected frames queued at send time and compared when the receiver reports them.
module tb_uart_rx_param;

  typedef struct {
    int         idx;
    logic [8:0] data;
    logic       ready;
    logic       perr;
    logic       ferr;
    logic       oerr;
    logic       brk;
  } exp_t;

  logic       sys_clk = 1'b0;
  logic       rst_n;
  logic       rx_clk_en = 1'b0;
  logic [2:0] rx_line;
  logic [2:0] clr;
  logic [2:0] rdy, pe, fe, oe, bk, bsy;
  logic [7:0] rd0, rd1;
  logic [6:0] rd2;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  uart_rx_param #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY(0), .STOP_BITS(1), .SYNC_STAGES(2)) u_8n1 (
    .sys_clk(sys_clk), .rst_n(rst_n), .rx_clk_en(rx_clk_en), .rx(rx_line[0]),
    .rx_data(rd0), .rx_ready(rdy[0]), .rx_ready_clear(clr[0]), .parity_err(pe[0]),
    .frame_err(fe[0]), .overrun_err(oe[0]), .break_det(bk[0]), .busy(bsy[0]));

  uart_rx_param #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY(2), .STOP_BITS(1), .SYNC_STAGES(2)) u_8e1 (
    .sys_clk(sys_clk), .rst_n(rst_n), .rx_clk_en(rx_clk_en), .rx(rx_line[1]),
    .rx_data(rd1), .rx_ready(rdy[1]), .rx_ready_clear(clr[1]), .parity_err(pe[1]),
    .frame_err(fe[1]), .overrun_err(oe[1]), .break_det(bk[1]), .busy(bsy[1]));

  uart_rx_param #(.DATA_BITS(7), .OVERSAMPLE(16), .PARITY(1), .STOP_BITS(2), .SYNC_STAGES(2)) u_7o2 (
    .sys_clk(sys_clk), .rst_n(rst_n), .rx_clk_en(rx_clk_en), .rx(rx_line[2]),
    .rx_data(rd2), .rx_ready(rdy[2]), .rx_ready_clear(clr[2]), .parity_err(pe[2]),
    .frame_err(fe[2]), .overrun_err(oe[2]), .break_det(bk[2]), .busy(bsy[2]));

  always #5 sys_clk = ~sys_clk;

  // Oversample tick: high for one sys_clk out of every two.
  initial begin
    forever begin
      @(posedge sys_clk);
      #1 rx_clk_en = ~rx_clk_en;
    end
  end

  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [8:0] data_of(input int idx);
    case (idx)
      0:       return {1'b0, rd0};
      1:       return {1'b0, rd1};
      default: return {2'b00, rd2};
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic wait_ticks(input int n);
    repeat (n) begin
      @(posedge sys_clk);
      while (!rx_clk_en) @(posedge sys_clk);
    end
    #2;
  endtask

  task automatic send_bit(input int idx, input logic b);
    rx_line[idx] = b;
    wait_ticks(16);
  endtask

  task automatic send_frame(input int idx, input logic [8:0] d, input int nbits,
                            input bit has_par, input logic par_bit,
                            input int nstops, input logic [1:0] stops);
    send_bit(idx, 1'b0);
    for (int i = 0; i < nbits; i++) send_bit(idx, d[i]);
    if (has_par) send_bit(idx, par_bit);
    for (int i = 0; i < nstops; i++) send_bit(idx, stops[i]);
    rx_line[idx] = 1'b1;
    wait_ticks(16);
  endtask

  task automatic push(input int idx, input logic [8:0] d, input logic ready,
                      input logic perr, input logic ferr, input logic oerr, input logic brk);
    exp_t e;
    e.idx = idx; e.data = d; e.ready = ready;
    e.perr = perr; e.ferr = ferr; e.oerr = oerr; e.brk = brk;
    sb.push_back(e);
  endtask

  task automatic check_output(input int idx);
    exp_t e;
    int   n;
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 32'd0, 32'd1);
      return;
    end
    e = sb.pop_front();
    chk($sformatf("d%0d_sb_idx", idx), idx, e.idx);
    n = 0;
    while (e.ready && !rdy[idx] && n < 400) begin
      @(negedge sys_clk);
      n++;
    end
    @(negedge sys_clk);
    chk($sformatf("d%0d_ready", idx), rdy[idx], e.ready);
    chk($sformatf("d%0d_data", idx), data_of(idx), e.data);
    chk($sformatf("d%0d_parity_err", idx), pe[idx], e.perr);
    chk($sformatf("d%0d_frame_err", idx), fe[idx], e.ferr);
    chk($sformatf("d%0d_overrun_err", idx), oe[idx], e.oerr);
    chk($sformatf("d%0d_break_det", idx), bk[idx], e.brk);
  endtask

  task automatic clear(input int idx);
    @(negedge sys_clk);
    clr[idx] = 1'b1;
    @(negedge sys_clk);
    clr[idx] = 1'b0;
    chk($sformatf("d%0d_ready_after_clear", idx), rdy[idx], 1'b0);
  endtask

  initial begin
    rst_n   = 1'b0;
    rx_line = 3'b111;
    clr     = 3'b000;
    repeat (5) @(negedge sys_clk);

    chk("reset_ready", rdy, 3'b000);
    chk("reset_busy", bsy, 3'b000);
    chk("reset_data0", data_of(0), 9'h000);
    chk("reset_flags", {pe, fe, oe, bk}, 12'h000);

    @(negedge sys_clk);
    rst_n = 1'b1;
    wait_ticks(8);

    // 8N1 0xA5, with busy watched across the stop bit
    $display("[TB] 8N1 frame 0xA5");
    push(0, 9'h0A5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    send_bit(0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      logic [7:0] v;
      v = 8'hA5;
      send_bit(0, v[i]);
    end
    rx_line[0] = 1'b1;
    wait_ticks(4);
    chk("busy_early_stop", bsy[0], 1'b1);
    wait_ticks(10);
    chk("busy_after_mid_stop", bsy[0], 1'b0);
    wait_ticks(2);
    check_output(0);
    clear(0);

    // 8E1 0x03 with wrong then correct parity bit
    $display("[TB] 8E1 parity");
    push(1, 9'h003, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    send_frame(1, 9'h003, 8, 1'b1, 1'b1, 1, 2'b01);
    check_output(1);
    clear(1);
    push(1, 9'h003, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    send_frame(1, 9'h003, 8, 1'b1, 1'b0, 1, 2'b01);
    check_output(1);
    clear(1);

    // False start, then a valid frame
    $display("[TB] false start");
    rx_line[0] = 1'b0;
    wait_ticks(4);
    rx_line[0] = 1'b1;
    wait_ticks(20);
    chk("false_start_busy", bsy[0], 1'b0);
    chk("false_start_ready", rdy[0], 1'b0);
    push(0, 9'h05A, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    send_frame(0, 9'h05A, 8, 1'b0, 1'b0, 1, 2'b01);
    check_output(0);
    clear(0);

    // Overrun: second frame dropped while first is unread
    $display("[TB] overrun");
    push(0, 9'h011, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    send_frame(0, 9'h011, 8, 1'b0, 1'b0, 1, 2'b01);
    check_output(0);
    push(0, 9'h011, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    send_frame(0, 9'h022, 8, 1'b0, 1'b0, 1, 2'b01);
    check_output(0);
    clear(0);
    chk("overrun_cleared", oe[0], 1'b0);
    push(0, 9'h033, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    send_frame(0, 9'h033, 8, 1'b0, 1'b0, 1, 2'b01);
    check_output(0);
    clear(0);

    // Break: line low for three frame times yields a single completion
    $display("[TB] break");
    rx_line[0] = 1'b0;
    wait_ticks(480);
    rx_line[0] = 1'b1;
    wait_ticks(32);
    push(0, 9'h000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    check_output(0);
    clear(0);
    push(0, 9'h07E, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    send_frame(0, 9'h07E, 8, 1'b0, 1'b0, 1, 2'b01);
    check_output(0);
    clear(0);

    // 7O2 0x41 (two ones, parity bit 1) with the second stop bit low
    $display("[TB] 7O2 framing");
    push(2, 9'h041, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    send_frame(2, 9'h041, 7, 1'b1, 1'b1, 2, 2'b01);
    check_output(2);

    // Reset mid-DATA while the previous frame is still held
    $display("[TB] reset mid-frame");
    send_bit(2, 1'b0);
    send_bit(2, 1'b1);
    send_bit(2, 1'b0);
    rx_line[2] = 1'b1;
    wait_ticks(4);
    chk("mid_data_busy", bsy[2], 1'b1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_busy", bsy[2], 1'b0);
    chk("rst_mid_ready", rdy[2], 1'b0);
    chk("rst_mid_data", data_of(2), 9'h000);
    chk("rst_mid_flags", {pe[2], fe[2], oe[2], bk[2]}, 4'h0);
    wait_ticks(4);
    @(negedge sys_clk);
    rst_n = 1'b1;
    wait_ticks(200);
    chk("rst_nothing_delivered", rdy[2], 1'b0);
    chk("rst_idle_busy", bsy[2], 1'b0);
    chk("scoreboard_drained", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
